// File: rtl/scaler_pkg.sv
// Shared types and sizes for the down-scaler sequencer.
// SCALER_WATCHDOG_EN (optional) adds a CAPTURE timeout to the top level.
package scaler_pkg;

    localparam int NUM_PIX = 400;
    localparam int ADDR_W  = 9;
    localparam int PIX_W   = 32;
    localparam int CNT_W   = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        CAPTURE = 3'd2,
        READOUT = 3'd3,
        DRAIN   = 3'd4
    } seq_state_e;

    // Plain-vector aliases so the FSM register stays a simple logic vector.
    localparam logic [2:0] ST_IDLE    = IDLE;
    localparam logic [2:0] ST_ARM     = ARM;
    localparam logic [2:0] ST_CAPTURE = CAPTURE;
    localparam logic [2:0] ST_READOUT = READOUT;
    localparam logic [2:0] ST_DRAIN   = DRAIN;

    function automatic logic isLastIndex(input logic [ADDR_W-1:0] addr);
        return addr == ADDR_W'(NUM_PIX - 1);
    endfunction

endpackage

// File: rtl/scaler_sequencer_pix_out_stage.sv
// One-entry valid/ready output register carrying a pixel and its last flag.
// Macro SCALER_WATCHDOG_EN has no effect on this stage.
module pix_out_stage
    import scaler_pkg::*;
#(
    parameter int W = PIX_W
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         last_i,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         last_o
);

    logic [W-1:0] data_q;
    logic         valid_q;
    logic         last_q;

    // A load always wins; otherwise an accepted beat empties the register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= 1'b1;
            last_q  <= last_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

// File: rtl/scaler_sequencer.sv
// Arms the down-scaler on a frame, enables its write phase, then streams its buffer out.
// Define SCALER_WATCHDOG_EN to bound the time spent waiting for the scaler in CAPTURE.
module scaler_sequencer
    import scaler_pkg::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 2_000_000
)
(
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic              continuous_i,
    input  logic              frame_valid_i,
    input  logic              scaler_done_i,
    output logic              scaler_write_o,
    output logic              scaler_read_o,
    output logic [ADDR_W-1:0] scaler_addr_o,
    input  logic [PIX_W-1:0]  pix_i,
    output logic [PIX_W-1:0]  pix_out_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              pix_last_o,
    output logic              busy_o,
    output logic              frame_error_o,
    output logic [CNT_W-1:0]  frame_count_o
);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              error_q, error_d;
    logic              fvPrev_q;
    logic              fvRise, fvFall;
    logic              load, loadLast;
    logic              timeout;

    assign fvRise   = frame_valid_i & ~fvPrev_q;
    assign fvFall   = ~frame_valid_i & fvPrev_q;
    assign loadLast = isLastIndex(addr_q);

`ifdef SCALER_WATCHDOG_EN
    logic [31:0] wdog_q;

    // Held at zero outside CAPTURE, so every entry starts a fresh count.
    always_ff @(posedge clk_i) begin
        if (reset_i || state_q != ST_CAPTURE) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + 32'd1;
        end
    end

    assign timeout = (state_q == ST_CAPTURE) && (wdog_q == WATCHDOG_CYCLES - 32'd1);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        error_d = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (fvRise) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // scaler_done outranks both a frame abort and a watchdog expiry.
                if (scaler_done_i) begin
                    state_d = ST_READOUT;
                end else if (fvFall) begin
                    error_d = 1'b1;
                    state_d = ST_ARM;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_READOUT: begin
                if (!pix_valid_o || pix_ready_i) begin
                    load = 1'b1;
                    if (loadLast) begin
                        addr_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (pix_valid_o && pix_ready_i) begin
                    count_d = count_q + CNT_W'(1);
                    state_d = continuous_i ? ST_ARM : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            error_q  <= 1'b0;
            fvPrev_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            count_q  <= count_d;
            error_q  <= error_d;
            fvPrev_q <= frame_valid_i;
        end
    end

    pix_out_stage #(
        .W(PIX_W)
    ) u_stage (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (load),
        .data_i (pix_i),
        .last_i (loadLast),
        .ready_i(pix_ready_i),
        .data_o (pix_out_o),
        .valid_o(pix_valid_o),
        .last_o (pix_last_o)
    );

    assign scaler_write_o = (state_q == ST_CAPTURE);
    assign scaler_read_o  = (state_q == ST_READOUT);
    assign scaler_addr_o  = addr_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign frame_error_o  = error_q;
    assign frame_count_o  = count_q;

endmodule

// File: tb/tb_scaler_sequencer.sv
// Directed self-checking bench for scaler_sequencer; covers the watchdog when
// SCALER_WATCHDOG_EN is defined (built with WATCHDOG_CYCLES = 100).
module tb_scaler_sequencer;
    import scaler_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              start, continuous, frameValid, scalerDone, pixReady;
    logic              scalerWrite, scalerRead, pixValid, pixLast, busy, frameError;
    logic [ADDR_W-1:0] scalerAddr;
    logic [PIX_W-1:0]  pixIn, pixOut;
    logic [CNT_W-1:0]  frameCount;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Scaler buffer model: read data is a combinational function of the address.
    always_comb pixIn = 32'h5A00_0000 + 32'(scalerAddr) * 32'd7;

    scaler_sequencer #(.WATCHDOG_CYCLES(100)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .continuous_i  (continuous),
        .frame_valid_i (frameValid),
        .scaler_done_i (scalerDone),
        .scaler_write_o(scalerWrite),
        .scaler_read_o (scalerRead),
        .scaler_addr_o (scalerAddr),
        .pix_i         (pixIn),
        .pix_out_o     (pixOut),
        .pix_valid_o   (pixValid),
        .pix_ready_i   (pixReady),
        .pix_last_o    (pixLast),
        .busy_o        (busy),
        .frame_error_o (frameError),
        .frame_count_o (frameCount)
    );

    function automatic logic [31:0] expectedPix(input int idx);
        return 32'h5A00_0000 + 32'(idx) * 32'd7;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s);
        start = s;
        stepClk();
        start = 1'b0;
    endtask

    // From ARM: rising frame edge, doneDelay cycles of CAPTURE, done lands with the frame fall.
    task automatic captureFrame(input int doneDelay);
        frameValid = 1'b0;
        stepClk();
        frameValid = 1'b1;
        stepClk();
        checkOutput("capture_write", 32'(scalerWrite), 32'd1);
        repeat (doneDelay - 1) stepClk();
        scalerDone = 1'b1;
        frameValid = 1'b0;
        stepClk();
        scalerDone = 1'b0;
        checkOutput("done_wins_no_error", 32'(frameError), 32'd0);
        checkOutput("readout_read", 32'(scalerRead), 32'd1);
        checkOutput("readout_no_write", 32'(scalerWrite), 32'd0);
        checkOutput("readout_addr0", 32'(scalerAddr), 32'd0);
        checkOutput("readout_first_invalid", 32'(pixValid), 32'd0);
    endtask

    // Consumes a full frame; mode 0 keeps ready high, mode 1 repeats ready 1,0,0,1.
    task automatic runFrame(input int mode);
        int          beat = 0;
        bit          finished = 1'b0;
        bit          stalled = 1'b0;
        logic [31:0] heldData = '0;
        logic [31:0] heldAddr = '0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            pixReady = (mode == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
            #1;
            if (stalled) begin
                checkOutput("stall_data", pixOut, heldData);
                checkOutput("stall_addr", 32'(scalerAddr), heldAddr);
            end
            if (scalerRead && scalerWrite) checkOutput("rw_exclusive", 32'd1, 32'd0);
            if (pixValid && pixReady) begin
                checkOutput($sformatf("beat%0d_data", beat), pixOut, expectedPix(beat));
                checkOutput($sformatf("beat%0d_last", beat), 32'(pixLast), (beat == NUM_PIX - 1) ? 32'd1 : 32'd0);
                if (beat == NUM_PIX - 1) finished = 1'b1;
                beat++;
            end
            stalled  = pixValid && !pixReady;
            heldData = pixOut;
            heldAddr = 32'(scalerAddr);
            stepClk();
        end
        checkOutput("frame_beats", 32'(beat), 32'(NUM_PIX));
        pixReady = 1'b1;
    endtask

    initial begin
        int beats;
        reset = 1'b1; start = 1'b0; continuous = 1'b0; frameValid = 1'b0;
        scalerDone = 1'b0; pixReady = 1'b1;
        repeat (3) stepClk();
        reset = 1'b0;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(pixValid), 32'd0);
        checkOutput("rst_write", 32'(scalerWrite), 32'd0);
        checkOutput("rst_read", 32'(scalerRead), 32'd0);
        checkOutput("rst_addr", 32'(scalerAddr), 32'd0);
        checkOutput("rst_count", 32'(frameCount), 32'd0);
        checkOutput("rst_error", 32'(frameError), 32'd0);

        $display("[TB] single frame, full throughput");
        applyStimulus(1'b1);
        checkOutput("arm_busy", 32'(busy), 32'd1);
        checkOutput("arm_no_write", 32'(scalerWrite), 32'd0);
        captureFrame(50);
        runFrame(0);
        checkOutput("f1_count", 32'(frameCount), 32'd1);
        checkOutput("f1_idle", 32'(busy), 32'd0);
        checkOutput("f1_valid_clear", 32'(pixValid), 32'd0);
        checkOutput("f1_last_clear", 32'(pixLast), 32'd0);

        $display("[TB] back-pressure 1,0,0,1");
        applyStimulus(1'b1);
        captureFrame(20);
        runFrame(1);
        checkOutput("f2_count", 32'(frameCount), 32'd2);
        checkOutput("f2_idle", 32'(busy), 32'd0);

        $display("[TB] running frame skipped, abort on early fall");
        frameValid = 1'b1;
        applyStimulus(1'b1);
        for (int i = 0; i < 5; i++) begin
            stepClk();
            checkOutput("arm_skip_running", 32'(scalerWrite), 32'd0);
        end
        frameValid = 1'b0;
        stepClk();
        checkOutput("arm_after_fall", 32'(scalerWrite), 32'd0);
        frameValid = 1'b1;
        stepClk();
        checkOutput("capture_after_rise", 32'(scalerWrite), 32'd1);
        repeat (10) stepClk();
        frameValid = 1'b0;
        stepClk();
        checkOutput("abort_error", 32'(frameError), 32'd1);
        checkOutput("abort_arm_busy", 32'(busy), 32'd1);
        checkOutput("abort_no_write", 32'(scalerWrite), 32'd0);
        checkOutput("abort_count", 32'(frameCount), 32'd2);
        stepClk();
        checkOutput("abort_pulse_end", 32'(frameError), 32'd0);
        captureFrame(10);
        runFrame(0);
        checkOutput("f3_count", 32'(frameCount), 32'd3);

        $display("[TB] continuous, three frames");
        continuous = 1'b1;
        applyStimulus(1'b1);
        for (int f = 0; f < 3; f++) begin
            captureFrame(5);
            if (f == 2) continuous = 1'b0;
            runFrame(0);
            checkOutput($sformatf("cont%0d_busy", f), 32'(busy), (f < 2) ? 32'd1 : 32'd0);
            checkOutput($sformatf("cont%0d_write", f), 32'(scalerWrite), 32'd0);
        end
        checkOutput("cont_count", 32'(frameCount), 32'd6);

        $display("[TB] reset mid-readout");
        continuous = 1'b1;
        applyStimulus(1'b1);
        captureFrame(5);
        pixReady = 1'b1;
        beats = 0;
        for (int cyc = 0; cyc < 1000 && beats < 200; cyc++) begin
            if (pixValid && pixReady) beats++;
            stepClk();
        end
        checkOutput("mid_beats", 32'(beats), 32'd200);
        reset = 1'b1;
        stepClk();
        checkOutput("mr_busy", 32'(busy), 32'd0);
        checkOutput("mr_valid", 32'(pixValid), 32'd0);
        checkOutput("mr_last", 32'(pixLast), 32'd0);
        checkOutput("mr_pix", pixOut, 32'd0);
        checkOutput("mr_read", 32'(scalerRead), 32'd0);
        checkOutput("mr_addr", 32'(scalerAddr), 32'd0);
        checkOutput("mr_error", 32'(frameError), 32'd0);
        checkOutput("mr_count", 32'(frameCount), 32'd0);
        reset = 1'b0;
        stepClk();
        checkOutput("mr_stays_idle", 32'(busy), 32'd0);
        checkOutput("mr_no_late_error", 32'(frameError), 32'd0);

        $display("[TB] capture with no scaler_done");
        continuous = 1'b1;
        applyStimulus(1'b1);
        frameValid = 1'b0;
        stepClk();
        frameValid = 1'b1;
        stepClk();
        checkOutput("wd_enter", 32'(scalerWrite), 32'd1);
        repeat (99) stepClk();
        checkOutput("wd_cycle100_write", 32'(scalerWrite), 32'd1);
        checkOutput("wd_cycle100_error", 32'(frameError), 32'd0);
        stepClk();
`ifdef SCALER_WATCHDOG_EN
        checkOutput("wd_idle", 32'(busy), 32'd0);
        checkOutput("wd_error", 32'(frameError), 32'd1);
        checkOutput("wd_no_write", 32'(scalerWrite), 32'd0);
        stepClk();
        checkOutput("wd_pulse_end", 32'(frameError), 32'd0);
`else
        checkOutput("nowd_busy", 32'(busy), 32'd1);
        checkOutput("nowd_write", 32'(scalerWrite), 32'd1);
        checkOutput("nowd_error", 32'(frameError), 32'd0);
        repeat (200) stepClk();
        checkOutput("nowd_still_capture", 32'(scalerWrite), 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
